// File: rtl/spi_flash_master_pkg.sv
// Shared definitions for the SPI flash master: register offsets, status layout, FSM states.
package spi_flash_master_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned DIV_W  = 8;
    localparam int unsigned BIT_W  = 3;

    localparam int unsigned SPI_DATA_OFS = 0;
    localparam int unsigned SPI_CTRL_OFS = 1;

    localparam int unsigned ST_BUSY = 0;
    localparam int unsigned ST_CS   = 1;
    localparam int unsigned ST_RXV  = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2
    } spi_state_e;

    // STATUS word as seen on the IO bus
    typedef struct packed {
        logic [DIV_W-1:0] div;
        logic [4:0]       rsvd;
        logic             rx_valid;
        logic             cs_en;
        logic             busy;
    } spi_status_t;

    function automatic spi_status_t pack_status(input logic [DIV_W-1:0] div,
                                                input logic rx_valid,
                                                input logic cs_en,
                                                input logic busy);
        spi_status_t s;
        s.div      = div;
        s.rsvd     = 5'd0;
        s.rx_valid = rx_valid;
        s.cs_en    = cs_en;
        s.busy     = busy;
        return s;
    endfunction

endpackage

// File: rtl/spi_halfper_tick.sv
// Loadable half-period down-counter; tick_c is high while the count sits at zero.
module spi_halfper_tick
    import spi_flash_master_pkg::*;
(
    input  logic             clk,
    input  logic             resetq,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    input  logic             dec,
    output logic             tick_c
);

    logic [DIV_W-1:0] hcnt_q, hcnt_d;

    always_comb begin
        hcnt_d = hcnt_q;
        if (load) begin
            hcnt_d = load_val;
        end else if (dec) begin
            hcnt_d = hcnt_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            hcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
        end
    end

    assign tick_c = (hcnt_q == '0);

endmodule

// File: rtl/spi_flash_master.sv
// Mode-0 SPI master on the j1 IO bus: DATA at BASE_ADDR, CTRL/STATUS at BASE_ADDR+1.
module spi_flash_master
    import spi_flash_master_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'd120,
    parameter logic [7:0]  DIV_RESET = 8'd1
) (
    input  logic              clk,
    input  logic              resetq,
    input  logic              io_wr,
    input  logic              io_rd,
    input  logic [DATA_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] dout,
    output logic [DATA_W-1:0] rdata,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic              spi_ssb
);

    localparam logic [DATA_W-1:0] DATA_ADDR = BASE_ADDR + DATA_W'(SPI_DATA_OFS);
    localparam logic [DATA_W-1:0] CTRL_ADDR = BASE_ADDR + DATA_W'(SPI_CTRL_OFS);

    spi_state_e        state_q, state_d;
    logic [BYTE_W-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0]  bitcnt_q, bitcnt_d;
    logic [BYTE_W-1:0] rx_byte_q, rx_byte_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              busy_q, busy_d;
    logic              rx_valid_q, rx_valid_d;
    logic              cs_en_q, cs_en_d;
    logic              sck_q, sck_d;
    logic              mosi_q, mosi_d;
    logic              ssb_q, ssb_d;

    logic data_sel_c, ctrl_sel_c;
    logic tick_c, tick_load_c, tick_dec_c;

    assign data_sel_c = (mem_addr == DATA_ADDR);
    assign ctrl_sel_c = (mem_addr == CTRL_ADDR);

    spi_halfper_tick u_tick (
        .clk      (clk),
        .resetq   (resetq),
        .load     (tick_load_c),
        .load_val (div_q),
        .dec      (tick_dec_c),
        .tick_c   (tick_c)
    );

    // Next-state and register-update logic
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bitcnt_d    = bitcnt_q;
        rx_byte_d   = rx_byte_q;
        div_d       = div_q;
        busy_d      = busy_q;
        rx_valid_d  = rx_valid_q;
        cs_en_d     = cs_en_q;
        sck_d       = sck_q;
        mosi_d      = mosi_q;
        tick_load_c = 1'b0;
        tick_dec_c  = 1'b0;

        if (io_rd && data_sel_c) begin
            rx_valid_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (io_wr && data_sel_c) begin
                    shreg_d     = dout[BYTE_W-1:0];
                    bitcnt_d    = '0;
                    tick_load_c = 1'b1;
                    busy_d      = 1'b1;
                    mosi_d      = dout[BYTE_W-1];
                    state_d     = S_LO;
                end
                // Control changes only land between frames
                if (io_wr && ctrl_sel_c) begin
                    cs_en_d = dout[0];
                    div_d   = dout[DATA_W-1:DATA_W-DIV_W];
                end
            end
            S_LO: begin
                if (tick_c) begin
                    sck_d       = 1'b1;
                    shreg_d     = {shreg_q[BYTE_W-2:0], spi_miso};
                    tick_load_c = 1'b1;
                    state_d     = S_HI;
                end else begin
                    tick_dec_c = 1'b1;
                end
            end
            S_HI: begin
                if (tick_c) begin
                    sck_d       = 1'b0;
                    tick_load_c = 1'b1;
                    if (bitcnt_q == BIT_W'(7)) begin
                        rx_byte_d  = shreg_q;
                        rx_valid_d = 1'b1;
                        busy_d     = 1'b0;
                        state_d    = S_IDLE;
                    end else begin
                        bitcnt_d = bitcnt_q + BIT_W'(1);
                        mosi_d   = shreg_q[BYTE_W-1];
                        state_d  = S_LO;
                    end
                end else begin
                    tick_dec_c = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ssb_d = ~cs_en_d;
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            bitcnt_q   <= '0;
            rx_byte_q  <= '0;
            div_q      <= DIV_RESET;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            cs_en_q    <= 1'b0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            ssb_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bitcnt_q   <= bitcnt_d;
            rx_byte_q  <= rx_byte_d;
            div_q      <= div_d;
            busy_q     <= busy_d;
            rx_valid_q <= rx_valid_d;
            cs_en_q    <= cs_en_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            ssb_q      <= ssb_d;
        end
    end

    // Read mux is combinational so it can join the io_din OR-tree directly
    always_comb begin
        rdata = '0;
        if (data_sel_c) begin
            rdata = {{(DATA_W-BYTE_W){1'b0}}, rx_byte_q};
        end else if (ctrl_sel_c) begin
            rdata = pack_status(div_q, rx_valid_q, cs_en_q, busy_q);
        end
    end

    assign spi_sck  = sck_q;
    assign spi_mosi = mosi_q;
    assign spi_ssb  = ssb_q;

    busy_tracks_state: assert property (@(posedge clk) disable iff (!resetq)
        busy_q == (state_q != S_IDLE));

endmodule

// File: tb/tb_spi_flash_master.sv
// Bench for spi_flash_master: vector table, randomized frames against a frame-level model, corner sequences.
module tb_spi_flash_master;

    localparam logic [15:0] DATA_A = 16'd120;
    localparam logic [15:0] CTRL_A = 16'd121;
    localparam int          LIMIT  = 6000;

    logic        clk;
    logic        resetq;
    logic        io_wr;
    logic        io_rd;
    logic [15:0] mem_addr;
    logic [15:0] dout;
    logic [15:0] rdata;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_ssb;

    int vectors;
    int miscompares;

    // Simple slave: presents slave_byte MSB first, advancing after each SCK rise
    logic [7:0] slave_byte;
    logic       loop_mode;
    int         rise_cnt;
    int         rise_base;
    logic [7:0] mosi_sh;
    logic [2:0] bit_idx;

    spi_flash_master dut (
        .clk      (clk),
        .resetq   (resetq),
        .io_wr    (io_wr),
        .io_rd    (io_rd),
        .mem_addr (mem_addr),
        .dout     (dout),
        .rdata    (rdata),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .spi_ssb  (spi_ssb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bit_idx  = 3'(rise_cnt - rise_base);
    assign spi_miso = loop_mode ? spi_mosi : slave_byte[3'd7 - bit_idx];

    initial begin
        rise_cnt = 0;
        mosi_sh  = 8'd0;
    end

    always @(posedge spi_sck) begin
        mosi_sh  = {mosi_sh[6:0], spi_mosi};
        rise_cnt = rise_cnt + 1;
    end

    typedef struct {
        logic [7:0]  div;
        logic        cs;
        logic [7:0]  tx;
        logic [7:0]  slave;
        logic        loop;
        logic [7:0]  exp_rx;
        int unsigned exp_cycles;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic io_write(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        mem_addr = a;
        dout     = d;
        io_wr    = 1'b1;
        @(negedge clk);
        io_wr    = 1'b0;
    endtask

    task automatic peek(input logic [15:0] a, output logic [15:0] d);
        mem_addr = a;
        #1;
        d = rdata;
    endtask

    task automatic read_clear(output logic [15:0] d);
        mem_addr = DATA_A;
        io_rd    = 1'b1;
        #1;
        d = rdata;
        @(negedge clk);
        io_rd = 1'b0;
    endtask

    // Counts cycles with busy set, bounded
    task automatic wait_idle(output int unsigned cycles);
        cycles   = 0;
        mem_addr = CTRL_A;
        #1;
        while (rdata[0] && cycles < LIMIT) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        if (cycles >= LIMIT) begin
            vectors++;
            miscompares++;
            $display("FAIL busy_timeout: busy still set after %0d cycles", cycles);
        end
    endtask

    // Frame-level reference: result byte and duration from the protocol rules
    function automatic vec_t model(input logic [7:0] div, input logic cs, input logic [7:0] tx,
                                   input logic [7:0] slave, input logic loop);
        vec_t v;
        v.div        = div;
        v.cs         = cs;
        v.tx         = tx;
        v.slave      = slave;
        v.loop       = loop;
        v.exp_rx     = loop ? tx : slave;
        v.exp_cycles = 16 * (int'(div) + 1);
        return v;
    endfunction

    task automatic run_frame(input vec_t v, input string tag);
        logic [15:0] d;
        int unsigned cyc;
        int          base;
        io_write(CTRL_A, {v.div, 7'd0, v.cs});
        check({tag, "_ssb"}, 32'(spi_ssb), 32'(!v.cs));
        slave_byte = v.slave;
        loop_mode  = v.loop;
        rise_base  = rise_cnt;
        base       = rise_cnt;
        io_write(DATA_A, {8'd0, v.tx});
        wait_idle(cyc);
        check({tag, "_cycles"}, 32'(cyc), 32'(v.exp_cycles));
        check({tag, "_sck_rises"}, 32'(rise_cnt - base), 32'd8);
        check({tag, "_mosi_bits"}, 32'(mosi_sh), 32'(v.tx));
        peek(CTRL_A, d);
        check({tag, "_status"}, 32'(d), 32'({v.div, 5'd0, 1'b1, v.cs, 1'b0}));
        read_clear(d);
        check({tag, "_rx"}, 32'(d), 32'({8'd0, v.exp_rx}));
        peek(CTRL_A, d);
        check({tag, "_rxv_clr"}, 32'(d[2]), 32'd0);
    endtask

    initial begin
        logic [15:0] d;
        int unsigned cyc;
        vec_t        v;

        vectors     = 0;
        miscompares = 0;
        resetq      = 1'b0;
        io_wr       = 1'b0;
        io_rd       = 1'b0;
        mem_addr    = 16'd0;
        dout        = 16'd0;
        slave_byte  = 8'd0;
        loop_mode   = 1'b0;
        rise_base   = 0;

        //                div    cs    tx     slave  loop  exp_rx cycles
        tbl[0] = '{8'd0,   1'b1, 8'hA5, 8'h00, 1'b1, 8'hA5, 16};
        tbl[1] = '{8'd3,   1'b1, 8'h3C, 8'hFF, 1'b0, 8'hFF, 64};
        tbl[2] = '{8'd1,   1'b0, 8'h81, 8'h5A, 1'b0, 8'h5A, 32};
        tbl[3] = '{8'd2,   1'b1, 8'h6E, 8'h00, 1'b1, 8'h6E, 48};
        tbl[4] = '{8'd255, 1'b1, 8'h00, 8'hC3, 1'b0, 8'hC3, 4096};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_sck", 32'(spi_sck), 32'd0);
        check("rst_ssb", 32'(spi_ssb), 32'd1);
        check("rst_mosi", 32'(spi_mosi), 32'd0);
        peek(CTRL_A, d);
        check("rst_status", 32'(d), 32'h0100);
        peek(16'd7, d);
        check("rdata_unaddressed", 32'(d), 32'd0);
        @(negedge clk);
        resetq = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_frame(tbl[i], $sformatf("tbl%0d", i));
        end

        for (int i = 0; i < 8; i++) begin
            v = model(8'($urandom_range(0, 5)), 1'($urandom), 8'($urandom), 8'($urandom),
                      1'($urandom_range(0, 3) == 0));
            run_frame(v, $sformatf("rnd%0d", i));
        end

        // Writes to DATA and CTRL while busy are dropped
        io_write(CTRL_A, 16'h0301);
        slave_byte = 8'h96;
        loop_mode  = 1'b0;
        rise_base  = rise_cnt;
        io_write(DATA_A, 16'h003C);
        repeat (4) @(negedge clk);
        io_write(DATA_A, 16'h0055);
        io_write(CTRL_A, 16'h0000);
        peek(CTRL_A, d);
        check("busy_wr_status", 32'(d & 16'hFF03), 32'h0303);
        check("busy_wr_ssb", 32'(spi_ssb), 32'd0);
        wait_idle(cyc);
        check("busy_wr_mosi", 32'(mosi_sh), 32'h3C);
        check("busy_wr_ssb_end", 32'(spi_ssb), 32'd0);
        repeat (4) @(negedge clk);
        peek(CTRL_A, d);
        check("busy_wr_no_restart", 32'(d), 32'h0306);
        read_clear(d);
        check("busy_wr_rx", 32'(d), 32'h0096);

        // Frame end coincides with a DATA read; rx_valid carried over from an unread frame
        io_write(CTRL_A, 16'h0001);
        slave_byte = 8'h11;
        rise_base  = rise_cnt;
        io_write(DATA_A, 16'h0000);
        wait_idle(cyc);
        slave_byte = 8'hE7;
        rise_base  = rise_cnt;
        io_write(DATA_A, 16'h000F);
        peek(CTRL_A, d);
        check("restart_rxv_kept", 32'(d[2:0]), 32'h7);
        repeat (15) @(negedge clk);
        peek(CTRL_A, d);
        check("last_cycle_busy", 32'(d[0]), 32'd1);
        mem_addr = DATA_A;
        io_rd    = 1'b1;
        @(negedge clk);
        io_rd = 1'b0;
        peek(CTRL_A, d);
        check("rd_vs_set_status", 32'(d), 32'h0006);
        peek(DATA_A, d);
        check("rd_vs_set_byte", 32'(d), 32'h00E7);

        // Asynchronous reset in the middle of a frame
        io_write(CTRL_A, 16'h0301);
        rise_base = rise_cnt;
        io_write(DATA_A, 16'h00A5);
        repeat (26) @(negedge clk);
        #2 resetq = 1'b0;
        #1;
        check("async_rst_ssb", 32'(spi_ssb), 32'd1);
        check("async_rst_sck", 32'(spi_sck), 32'd0);
        check("async_rst_mosi", 32'(spi_mosi), 32'd0);
        peek(CTRL_A, d);
        check("async_rst_status", 32'(d), 32'h0100);
        @(negedge clk);
        resetq = 1'b1;
        repeat (10) @(negedge clk);
        peek(CTRL_A, d);
        check("post_rst_idle", 32'(d), 32'h0100);
        check("post_rst_sck", 32'(spi_sck), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
